pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Sequences the 5-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM).
//   - Detects load-use hazards; stalls IF/ID and inserts an ID/EX bubble.
//   - Tracks the multi-cycle mul/div unit (MDU) with a busy counter.
//   - Flushes younger stages on a branch/jump redirect resolved in MEM.
// PARAMETERS
//   MUL_CYCLES  4   cycles an MDU multiply occupies (>=1)
//   DIV_CYCLES  32  cycles an MDU divide occupies (>=1, >=MUL_CYCLES)
//   CNT_W       6   MDU counter width; must hold DIV_CYCLES-1
// PORTS
//   clk               in   1  pipeline clock; all state updates on posedge clk
//   rst               in   1  synchronous active-high reset
//   id_rs             in   5  rs field of the instruction in ID
//   id_rt             in   5  rt field of the instruction in ID
//   id_uses_rs        in   1  ID instruction reads rs
//   id_uses_rt        in   1  ID instruction reads rt
//   ex_MemtoReg       in   2  EX-stage MemtoReg; 2'b01 = load
//   ex_RegWr          in   1  EX-stage register write enable
//   ex_Rw             in   5  EX-stage destination register
//   id_mdu_start      in   1  ID instruction is mult/div (issues to MDU)
//   id_mdu_div        in   1  1 = div, 0 = mult; valid with id_mdu_start
//   id_mdu_read       in   1  ID instruction is mfhi/mflo
//   mem_redirect      in   1  branch taken or jump resolved in MEM
//   pc_wr             out  1  PC write enable
//   ifid_wr           out  1  IF/ID register write enable
//   ifid_flush        out  1  IF/ID register loads a NOP
//   idex_flush        out  1  ID/EX register loads a bubble (all controls 0)
//   exmem_flush       out  1  EX/MEM register loads a bubble
//   mdu_busy          out  1  MDU counter nonzero
//   mdu_issue         out  1  MDU start accepted this cycle
// BEHAVIOUR
//   State: mdu_cnt[CNT_W-1:0] is the only registered state (plus perf counter).
//   All outputs are combinational from state and inputs.
//   Reset:
//     - While rst=1: mdu_cnt<=0; pc_wr=0, ifid_wr=0, mdu_issue=0, mdu_busy=0.
//     - ifid_flush, idex_flush and exmem_flush are held at 1.
//     - A reset mid-divide abandons the divide; mdu_busy=0 in the first cycle after rst falls.
//   Terms:
//     lu    = ex_MemtoReg==2'b01 & ex_RegWr & ex_Rw!=0 &
//             ((id_uses_rs & id_rs==ex_Rw) | (id_uses_rt & id_rt==ex_Rw))
//     mduhz = mdu_busy & (id_mdu_start | id_mdu_read)
//     stall = (lu | mduhz) & ~mem_redirect
//   Priority (highest first):
//     1. mem_redirect: pc_wr=1, ifid_wr=1, and all three flush outputs=1.
//        Any ID-stage start is discarded (mdu_issue=0), but an in-flight MDU keeps counting.
//     2. stall: pc_wr=0, ifid_wr=0, idex_flush=1, ifid_flush=0, exmem_flush=0.
//     3. else: pc_wr=1, ifid_wr=1, all flushes 0.
//   MDU counter:
//     - mdu_issue = id_mdu_start & ~mdu_busy & ~mem_redirect & ~lu.
//     - On issue, mdu_cnt <= (id_mdu_div ? DIV_CYCLES : MUL_CYCLES) - 1.
//     - Otherwise, if mdu_cnt != 0, decrement. The counter never wraps below 0.
//     - mdu_busy = (mdu_cnt != 0); CYCLES=1 gives zero busy cycles.
//     - A start/read arriving in the cycle mdu_cnt reaches 0 proceeds without a stall.
//   Load-use latency: exactly one bubble; the stalled instruction re-evaluates
//   next cycle, when the load has moved to MEM and lu=0.
//   Simultaneous lu and mduhz: a single combined stall; the counter keeps decrementing.
//   An ex_Rw of 0 never causes a stall.
// CONFIGURATION
//   HAZARD_PERF_EN defined:
//     - Adds output stall_cycles [31:0], reset to 0.
//     - Increments on every cycle where stall=1 and rst=0; saturates at 32'hFFFFFFFF.
//   Not defined: port and logic absent; all other behaviour identical.
// TESTING
//   1. rst=1 for 2 cycles -> all three flushes=1, pc_wr=0, mdu_busy=0.
//      Cycle after release -> pc_wr=1, flushes=0.
//   2. EX lw to $8 (ex_MemtoReg=01, ex_RegWr=1, ex_Rw=8); ID id_rs=8, id_uses_rs=1
//      -> 1 cycle of pc_wr=0, ifid_wr=0, idex_flush=1; next cycle (EX=bubble) no stall.
//   3. Same as 2 but ex_Rw=0, or id_uses_rs=0 -> no stall.
//   4. id_mdu_start, id_mdu_div=1 -> mdu_issue=1; mdu_busy=1 for exactly 31 cycles.
//      An mfhi in ID during that window stalls until mdu_busy=0, then passes.
//   5. mem_redirect=1 together with a load-use hazard and id_mdu_start
//      -> all flushes=1, pc_wr=1, mdu_issue=0, mdu_cnt unchanged.
//   6. With HAZARD_PERF_EN: run scenarios 2 and 4 back to back
//      -> stall_cycles = 1 + number of mfhi stall cycles; rst clears it to 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencing for the 5-stage MIPS core.
// Handles load-use stalls, multi-cycle MDU occupancy and MEM-stage redirect flushes.
// Optional build macro: HAZARD_PERF_EN adds the stall_cycles performance counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [1:0] ex_MemtoReg,
    input  logic       ex_RegWr,
    input  logic [4:0] ex_Rw,
    input  logic       id_mdu_start,
    input  logic       id_mdu_div,
    input  logic       id_mdu_read,
    input  logic       mem_redirect,
    output logic       pc_wr,
    output logic       ifid_wr,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       mdu_busy,
    output logic       mdu_issue
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [CNT_W-1:0] r_mdu_cnt;
    logic             w_busy;
    logic             w_lu;
    logic             w_mduhz;
    logic             w_stall;
    logic             w_issue;

    // Hazard terms; busy is forced low during reset so nothing stalls or issues then
    always_comb begin
        w_busy  = (r_mdu_cnt != '0) & ~rst;
        w_lu    = (ex_MemtoReg == 2'b01) & ex_RegWr & (ex_Rw != 5'd0) &
                  ((id_uses_rs & (id_rs == ex_Rw)) | (id_uses_rt & (id_rt == ex_Rw)));
        w_mduhz = w_busy & (id_mdu_start | id_mdu_read);
        w_stall = (w_lu | w_mduhz) & ~mem_redirect & ~rst;
        w_issue = id_mdu_start & ~w_busy & ~mem_redirect & ~w_lu & ~rst;
    end

    // Pipeline register controls: reset, then redirect, then stall, then normal flow
    always_comb begin
        pc_wr       = 1'b1;
        ifid_wr     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (rst) begin
            pc_wr       = 1'b0;
            ifid_wr     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_stall) begin
            pc_wr      = 1'b0;
            ifid_wr    = 1'b0;
            idex_flush = 1'b1;
        end
        mdu_busy  = w_busy;
        mdu_issue = w_issue;
    end

    // MDU occupancy counter: load on issue, otherwise count down to zero and hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mdu_cnt <= '0;
        end else if (w_issue) begin
            r_mdu_cnt <= id_mdu_div ? DIV_LOAD : MUL_LOAD;
        end else if (r_mdu_cnt != '0) begin
            r_mdu_cnt <= r_mdu_cnt - 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a timestamp-based reference model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_Rw;
    logic       id_uses_rs, id_uses_rt, ex_RegWr;
    logic [1:0] ex_MemtoReg;
    logic       id_mdu_start, id_mdu_div, id_mdu_read, mem_redirect;
    logic       pc_wr, ifid_wr, ifid_flush, idex_flush, exmem_flush, mdu_busy, mdu_issue;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state: cycle index and the first cycle at which the MDU is free
    longint unsigned cyc = 0;
    longint unsigned busy_end = 0;
    longint unsigned perf = 0;
    logic obs_busy;
    logic obs_pc;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_MemtoReg(ex_MemtoReg), .ex_RegWr(ex_RegWr), .ex_Rw(ex_Rw),
        .id_mdu_start(id_mdu_start), .id_mdu_div(id_mdu_div), .id_mdu_read(id_mdu_read),
        .mem_redirect(mem_redirect),
        .pc_wr(pc_wr), .ifid_wr(ifid_wr), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .mdu_busy(mdu_busy), .mdu_issue(mdu_issue)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One pipeline cycle: drive inputs, check outputs against the model, advance the clock
    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [1:0] mtr,
                        input logic rwe, input logic [4:0] rw, input logic st,
                        input logic dv, input logic rd, input logic rdr);
        logic busy, lu, stall, issue;
        logic e_pc, e_ifid, e_iff, e_idf, e_exf;
        rst = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        ex_MemtoReg = mtr; ex_RegWr = rwe; ex_Rw = rw;
        id_mdu_start = st; id_mdu_div = dv; id_mdu_read = rd; mem_redirect = rdr;
        #2;
        busy  = !r && (cyc < busy_end);
        lu    = (mtr == 2'b01) && rwe && (rw != 0) &&
                ((urs && rs == rw) || (urt && rt == rw));
        stall = !r && !rdr && (lu || (busy && (st || rd)));
        issue = !r && st && !busy && !rdr && !lu;
        if (r)          {e_pc, e_ifid, e_iff, e_idf, e_exf} = 5'b00111;
        else if (rdr)   {e_pc, e_ifid, e_iff, e_idf, e_exf} = 5'b11111;
        else if (stall) {e_pc, e_ifid, e_iff, e_idf, e_exf} = 5'b00010;
        else            {e_pc, e_ifid, e_iff, e_idf, e_exf} = 5'b11000;
        chk("pc_wr", 32'(pc_wr), 32'(e_pc));
        chk("ifid_wr", 32'(ifid_wr), 32'(e_ifid));
        chk("ifid_flush", 32'(ifid_flush), 32'(e_iff));
        chk("idex_flush", 32'(idex_flush), 32'(e_idf));
        chk("exmem_flush", 32'(exmem_flush), 32'(e_exf));
        chk("mdu_busy", 32'(mdu_busy), 32'(busy));
        chk("mdu_issue", 32'(mdu_issue), 32'(issue));
`ifdef HAZARD_PERF_EN
        chk("stall_cycles", stall_cycles, 32'(perf));
`endif
        obs_busy = mdu_busy;
        obs_pc   = pc_wr;
        @(posedge clk);
        if (r) begin
            busy_end = 0;
            perf     = 0;
        end else begin
            if (issue) busy_end = cyc + (dv ? 32 : 4);
            if (stall && perf != 64'hFFFF_FFFF) perf++;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input logic r);
        step(r, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int unsigned n;
        logic [31:0] perf_base;
        @(posedge clk); #1;

        // Reset for two cycles, then release
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // Load-use on rs: one bubble, then the re-evaluated instruction passes
        step(1'b0, 5'd8, 5'd3, 1'b1, 1'b1, 2'b01, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_stall_pc", 32'(obs_pc), 32'd0);
        step(1'b0, 5'd8, 5'd3, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Load-use on rt
        step(1'b0, 5'd1, 5'd9, 1'b0, 1'b1, 2'b01, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        // No stall: destination $0, or rs not used
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b01, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd8, 5'd3, 1'b0, 1'b0, 2'b01, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        // Not a load (MemtoReg=10) -> no stall
        step(1'b0, 5'd8, 5'd3, 1'b1, 1'b0, 2'b10, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);

        // Divide: busy for exactly 31 cycles; mfhi in ID stalls throughout, then passes
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (!obs_busy) break;
            n++;
        end
        chk("div_busy_len", n, 32'd31);

        // Multiply then redirect with load-use and a new start: flush, no issue, MDU keeps counting
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 2'b01, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 2'b01, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Start arriving the cycle the counter reaches zero proceeds
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Reset mid-operation abandons it
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

`ifdef HAZARD_PERF_EN
        // One load-use stall followed by the divide/mfhi window
        perf_base = 32'(perf);
        step(1'b0, 5'd8, 5'd3, 1'b1, 1'b1, 2'b01, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (!obs_busy) break;
        end
        chk("perf_total", stall_cycles - perf_base, 32'd32);
        idle(1'b1);
        idle(1'b0);
`else
        perf_base = 32'd0;
        idle(1'b0);
`endif

        // Randomized traffic with narrow register ranges to provoke collisions
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(99) == 0),
                 5'($urandom_range(3)), 5'($urandom_range(3)),
                 1'($urandom), 1'($urandom),
                 2'($urandom), 1'($urandom), 5'($urandom_range(3)),
                 ($urandom_range(5) == 0), 1'($urandom), ($urandom_range(3) == 0),
                 ($urandom_range(11) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
